// File: rtl/pipelined_fadd_if.sv
// Operand/result bundle for the pipelined single-precision adder.
// Handshake semantics: there is no valid/ready pair. The adder samples A, B
// and operation on every rising clock edge and presents that op's result
// three edges later; the consumer tracks validity by counting that latency.
interface pipelined_fadd_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        operation;
  logic [31:0] result;

  modport master (
    output A,
    output B,
    output operation,
    input  result
  );

  modport slave (
    input  A,
    input  B,
    input  operation,
    output result
  );
endinterface

// File: rtl/pipelined_fadd.sv
// Four-stage pipelined IEEE-754 single-precision add/subtract.
// Stage 1 unpack/compare/specials, stage 2 align, stage 3 add/sub,
// stage 4 normalize/round/pack (the result register).
// Denormal inputs are read as zero and tiny results flush to zero.
// Optional feature macro: FADD_ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the datapath truncates (round toward zero).
// There is no FSM; the pipeline is a straight register chain with no stalls.
module pipelined_fadd (
  input logic             clk,
  input logic             rst,
  pipelined_fadd_if.slave bus
);

  // Number of leading zeros in a 27-bit significand (27 when all zero).
  function automatic logic [4:0] lead_zeros(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------- stage 1
  logic [31:0] b_eff;
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [30:0] a_key, b_key;
  logic [23:0] a_sig, b_sig;
  logic        swap;
  logic        c1_special;
  logic [31:0] c1_special_val;

  logic        s1_sign, s1_sub, s1_special;
  logic [31:0] s1_special_val;
  logic [7:0]  s1_exp, s1_diff;
  logic [23:0] s1_mx, s1_my;

  // Unpack both operands, apply DAZ, flag specials and order by magnitude.
  always_comb begin
    b_eff  = {bus.B[31] ^ bus.operation, bus.B[30:0]};
    a_sign = bus.A[31];
    b_sign = b_eff[31];
    a_exp  = bus.A[30:23];
    b_exp  = b_eff[30:23];
    a_zero = (a_exp == 8'd0);
    b_zero = (b_exp == 8'd0);
    a_inf  = (a_exp == 8'hFF) && (bus.A[22:0] == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (b_eff[22:0] == 23'd0);
    a_nan  = (a_exp == 8'hFF) && (bus.A[22:0] != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (b_eff[22:0] != 23'd0);
    a_key  = a_zero ? 31'd0 : bus.A[30:0];
    b_key  = b_zero ? 31'd0 : b_eff[30:0];
    a_sig  = a_zero ? 24'd0 : {1'b1, bus.A[22:0]};
    b_sig  = b_zero ? 24'd0 : {1'b1, b_eff[22:0]};
    swap   = (b_key > a_key);

    c1_special     = 1'b0;
    c1_special_val = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      c1_special     = 1'b1;
      c1_special_val = 32'h7FC0_0000;
    end else if (a_inf) begin
      c1_special     = 1'b1;
      c1_special_val = {a_sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      c1_special     = 1'b1;
      c1_special_val = {b_sign, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      c1_special     = 1'b1;
      c1_special_val = {a_sign & b_sign, 31'd0};
    end
  end

  // Stage-1 register: larger operand X, smaller Y, exponent gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sign        <= 1'b0;
      s1_sub         <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_val <= 32'h0;
      s1_exp         <= 8'd0;
      s1_diff        <= 8'd0;
      s1_mx          <= 24'd0;
      s1_my          <= 24'd0;
    end else begin
      s1_sign        <= swap ? b_sign : a_sign;
      s1_sub         <= a_sign ^ b_sign;
      s1_special     <= c1_special;
      s1_special_val <= c1_special_val;
      s1_exp         <= swap ? b_exp : a_exp;
      s1_diff        <= swap ? (b_exp - a_exp) : (a_exp - b_exp);
      s1_mx          <= swap ? b_sig : a_sig;
      s1_my          <= swap ? a_sig : b_sig;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [53:0] align_wide;
  logic [26:0] c2_my;

  logic        s2_sign, s2_sub, s2_special;
  logic [31:0] s2_special_val;
  logic [7:0]  s2_exp;
  logic [26:0] s2_mx, s2_my;

  // Right-shift Y into 24+G/R/S; everything shifted past S folds into S.
  always_comb begin
    align_wide = {s1_my, 3'b000, 27'd0} >> s1_diff;
    if (s1_diff >= 8'd27) c2_my = {26'd0, |s1_my};
    else                  c2_my = {align_wide[53:28], align_wide[27] | (|align_wide[26:0])};
  end

  // Stage-2 register: aligned significands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_sign        <= 1'b0;
      s2_sub         <= 1'b0;
      s2_special     <= 1'b0;
      s2_special_val <= 32'h0;
      s2_exp         <= 8'd0;
      s2_mx          <= 27'd0;
      s2_my          <= 27'd0;
    end else begin
      s2_sign        <= s1_sign;
      s2_sub         <= s1_sub;
      s2_special     <= s1_special;
      s2_special_val <= s1_special_val;
      s2_exp         <= s1_exp;
      s2_mx          <= {s1_mx, 3'b000};
      s2_my          <= c2_my;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [27:0] c3_sum;

  logic        s3_sign, s3_special;
  logic [31:0] s3_special_val;
  logic [7:0]  s3_exp;
  logic [27:0] s3_sum;

  // X is never smaller than Y, so the difference cannot go negative.
  always_comb begin
    if (s2_sub) c3_sum = {1'b0, s2_mx} - {1'b0, s2_my};
    else        c3_sum = {1'b0, s2_mx} + {1'b0, s2_my};
  end

  // Stage-3 register: raw sum; an exact cancellation is forced to +0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_sign        <= 1'b0;
      s3_special     <= 1'b0;
      s3_special_val <= 32'h0;
      s3_exp         <= 8'd0;
      s3_sum         <= 28'd0;
    end else begin
      s3_sign        <= (c3_sum == 28'd0) ? 1'b0 : s2_sign;
      s3_special     <= s2_special;
      s3_special_val <= s2_special_val;
      s3_exp         <= s2_exp;
      s3_sum         <= c3_sum;
    end
  end

  // ---------------------------------------------------------------- stage 4
  logic [4:0]        lz;
  logic signed [9:0] exp_n, exp_f;
  logic [24:0]       mant25;
  logic [22:0]       mant_f;
  logic [31:0]       next_result;
`ifdef FADD_ROUND_NEAREST_EN
  logic [26:0]       norm27;
  logic              round_up;
`else
  logic [23:0]       norm24;
`endif

  // Normalize, round, re-normalize on rounding carry, then pack or saturate.
  always_comb begin
    lz = lead_zeros(s3_sum[26:0]);
`ifdef FADD_ROUND_NEAREST_EN
    if (s3_sum[27]) begin
      norm27 = {s3_sum[27:2], s3_sum[1] | s3_sum[0]};
      exp_n  = $signed({2'b00, s3_exp}) + 10'sd1;
    end else begin
      norm27 = s3_sum[26:0] << lz;
      exp_n  = $signed({2'b00, s3_exp}) - $signed({5'd0, lz});
    end
    round_up = norm27[2] & (norm27[1] | norm27[0] | norm27[3]);
    mant25   = {1'b0, norm27[26:3]} + {24'd0, round_up};
`else
    if (s3_sum[27]) begin
      norm24 = s3_sum[27:4];
      exp_n  = $signed({2'b00, s3_exp}) + 10'sd1;
    end else begin
      norm24 = 24'((s3_sum[26:0] << lz) >> 3);
      exp_n  = $signed({2'b00, s3_exp}) - $signed({5'd0, lz});
    end
    mant25 = {1'b0, norm24};
`endif
    if (mant25[24]) begin
      mant_f = mant25[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      mant_f = mant25[22:0];
      exp_f  = exp_n;
    end

    if (s3_special)               next_result = s3_special_val;
    else if (s3_sum == 28'd0)     next_result = {s3_sign, 31'd0};
    else if (exp_f >= 10'sd255)   next_result = {s3_sign, 8'hFF, 23'd0};
    else if (exp_f <= 10'sd0)     next_result = {s3_sign, 31'd0};
    else                          next_result = {s3_sign, exp_f[7:0], mant_f};
  end

  // Stage-4 register drives the result directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.result <= 32'h0;
    else      bus.result <= next_result;
  end

endmodule

// File: tb/tb_pipelined_fadd.sv
// Directed bench for pipelined_fadd: single ops, a back-to-back stream
// checked through an expected queue, and asynchronous reset mid-stream.
module tb_pipelined_fadd;

  localparam int N_VEC = 22;

  logic clk;
  logic rst;
  pipelined_fadd_if bus ();

  pipelined_fadd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ------------------------------------------------ clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------ directed vectors
  logic [31:0] vec_a   [N_VEC];
  logic [31:0] vec_b   [N_VEC];
  logic        vec_op  [N_VEC];
  logic [31:0] vec_exp [N_VEC];

  // ------------------------------------------------ scoreboard
  logic [31:0] exp_q[$];
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // ------------------------------------------------ driver tasks
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge clk);
    bus.A         = a;
    bus.B         = b;
    bus.operation = op;
  endtask

  // One op in isolation: sampled at edge n, checked just after edge n+3.
  task automatic run_single(input int idx);
    drive(vec_a[idx], vec_b[idx], vec_op[idx]);
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("single[%0d]", idx), bus.result, vec_exp[idx]);
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] e);
    vec_a[i]   = a;
    vec_b[i]   = b;
    vec_op[i]  = op;
    vec_exp[i] = e;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    set_vec( 0, 32'h415A6666, 32'h41241687, 1'b0, 32'h41BF3E76); // 13.65 + 10.2555
    set_vec( 1, 32'h415A6666, 32'h41241687, 1'b1, 32'h40593F7C);
    set_vec( 2, 32'hC15A6666, 32'h41241687, 1'b0, 32'hC0593F7C);
    set_vec( 3, 32'hC15A6666, 32'h41241687, 1'b1, 32'hC1BF3E76);
    set_vec( 4, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000); // +Inf + -Inf
    set_vec( 5, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000); // Inf + 1
    set_vec( 6, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000); // overflow
    set_vec( 7, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000); // 1 - 1
    set_vec( 8, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000); // 1 + 1
    set_vec( 9, 32'h00000001, 32'h00000000, 1'b0, 32'h00000000); // DAZ
    set_vec(10, 32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000); // NaN payload dropped
    set_vec(11, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000); // -0 + -0
    set_vec(12, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000); // +0 - +0
    set_vec(13, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000); // -0 - +0
    set_vec(14, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000); // Inf - Inf
    set_vec(15, 32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000); // -Inf + -Inf
    set_vec(16, 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000); // 1 + -1
    set_vec(17, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000); // 1 + 2
    set_vec(18, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000); // 3 - 1
    set_vec(19, 32'h00800000, 32'h00800001, 1'b1, 32'h80000000); // FTZ, signed
    set_vec(20, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000); // tie, LSB 0
    set_vec(21, 32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000); // gap >= 27

    // Reset asserted from time zero: result must read zero.
    rst           = 1'b0;
    bus.A         = 32'h0;
    bus.B         = 32'h0;
    bus.operation = 1'b0;
    #1;
    check("reset_state", bus.result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Each vector in isolation.
    for (int i = 0; i < N_VEC; i++) run_single(i);

    // Back-to-back stream: op k sampled at edge k, result checked after edge k+3.
    for (int k = 0; k < N_VEC + 3; k++) begin
      @(negedge clk);
      if (k < N_VEC) begin
        bus.A         = vec_a[k];
        bus.B         = vec_b[k];
        bus.operation = vec_op[k];
        exp_q.push_back(vec_exp[k]);
      end
      @(posedge clk);
      #1;
      if (k >= 3) begin
        if (exp_q.size() == 0) check("stream_queue_empty", 32'h1, 32'h0);
        else check($sformatf("stream[%0d]", k - 3), bus.result, exp_q.pop_front());
      end
    end

    // Mid-stream asynchronous reset.
    drive(32'h3F800000, 32'h3F800000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset", bus.result, 32'h40000000);
    drive(32'h415A6666, 32'h41241687, 1'b0);
    @(posedge clk);
    drive(32'h7F800000, 32'h3F800000, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", bus.result, 32'h0);
    @(posedge clk);
    #1;
    check("reset_low_edge", bus.result, 32'h0);

    // Release and apply a new op at edge m in the same half cycle.
    @(negedge clk);
    rst           = 1'b1;
    bus.A         = 32'h3F800000;
    bus.B         = 32'h40000000;
    bus.operation = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_m+%0d", e), bus.result, 32'h0);
    end
    @(posedge clk);
    #1;
    check("post_reset_m+3", bus.result, 32'h40400000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
